// File: rtl/riscpipe_pkg.sv
// Shared MEM->WB definitions: default widths, writeback payload
// layout and the all-control-zero bubble value.
package riscpipe_pkg;
  localparam int WB_DATA_W  = 16;
  localparam int WB_RDEST_W = 3;

  typedef struct packed {
    logic [WB_DATA_W-1:0]  result;
    logic [WB_RDEST_W-1:0] rdest;
    logic                  w_reg;
    logic                  stop;
    logic [WB_DATA_W-1:0]  pc;
    logic                  bpr;
  } wb_payload_t;

  localparam wb_payload_t WB_BUBBLE = '0;
endpackage

// File: rtl/mem_wb_elastic_stage_reg.sv
// Writeback payload register: load enable, clear, and bubble gating
// that zeroes control fields while leaving result/pc untouched.
module wb_payload_reg #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          load,
  input  logic          d_valid,
  input  logic [DW-1:0] d_result,
  input  logic [RW-1:0] d_rdest,
  input  logic          d_w_reg,
  input  logic          d_stop,
  input  logic [DW-1:0] d_pc,
  input  logic          d_bpr,
  output logic          q_valid,
  output logic [DW-1:0] q_result,
  output logic [RW-1:0] q_rdest,
  output logic          q_w_reg,
  output logic          q_stop,
  output logic [DW-1:0] q_pc,
  output logic          q_bpr
);
  logic          valid_q, valid_d;
  logic [DW-1:0] result_q, result_d;
  logic [RW-1:0] rdest_q, rdest_d;
  logic          w_reg_q, w_reg_d;
  logic          stop_q, stop_d;
  logic [DW-1:0] pc_q, pc_d;
  logic          bpr_q, bpr_d;

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    rdest_d  = rdest_q;
    w_reg_d  = w_reg_q;
    stop_d   = stop_q;
    pc_d     = pc_q;
    bpr_d    = bpr_q;
    if (clr || (load && !d_valid)) begin
      // Bubble: kill control only, data lines stay quiet
      valid_d = 1'b0;
      rdest_d = '0;
      w_reg_d = 1'b0;
      stop_d  = 1'b0;
      bpr_d   = 1'b0;
    end else if (load) begin
      valid_d  = 1'b1;
      result_d = d_result;
      rdest_d  = d_rdest;
      w_reg_d  = d_w_reg;
      stop_d   = d_stop;
      pc_d     = d_pc;
      bpr_d    = d_bpr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      rdest_q  <= '0;
      w_reg_q  <= 1'b0;
      stop_q   <= 1'b0;
      pc_q     <= '0;
      bpr_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      rdest_q  <= rdest_d;
      w_reg_q  <= w_reg_d;
      stop_q   <= stop_d;
      pc_q     <= pc_d;
      bpr_q    <= bpr_d;
    end
  end

  assign q_valid  = valid_q;
  assign q_result = result_q;
  assign q_rdest  = rdest_q;
  assign q_w_reg  = w_reg_q;
  assign q_stop   = stop_q;
  assign q_pc     = pc_q;
  assign q_bpr    = bpr_q;
endmodule

// File: rtl/mem_wb_elastic_stage.sv
// Elastic MEM->WB stage: head register plus optional skid entry,
// back-pressure stalls, flush and a forwarding tap.
module mem_wb_elastic_stage
  import riscpipe_pkg::*;
#(
  parameter int DATA_W  = WB_DATA_W,
  parameter int RDEST_W = WB_RDEST_W,
  parameter bit SKID    = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_result,
  input  logic [RDEST_W-1:0] in_rdest,
  input  logic               in_w_reg,
  input  logic               in_stop,
  input  logic [DATA_W-1:0]  in_pc,
  input  logic               in_bpr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic [RDEST_W-1:0] out_rdest,
  output logic               out_w_reg,
  output logic               out_stop,
  output logic [DATA_W-1:0]  out_pc,
  output logic               out_bpr,
  output logic               fwd_valid,
  output logic [1:0]         occupancy
);
  logic               accept;
  logic               h_valid;
  logic               h_load;
  logic               s_valid;
  logic               m_valid;
  logic [DATA_W-1:0]  m_result;
  logic [RDEST_W-1:0] m_rdest;
  logic               m_w_reg;
  logic               m_stop;
  logic [DATA_W-1:0]  m_pc;
  logic               m_bpr;

  assign accept = in_valid & in_ready & ~flush;
  assign h_load = ~h_valid | out_ready;

  if (SKID) begin : g_skid
    logic               s_load;
    logic [DATA_W-1:0]  s_result;
    logic [RDEST_W-1:0] s_rdest;
    logic               s_w_reg;
    logic               s_stop;
    logic [DATA_W-1:0]  s_pc;
    logic               s_bpr;

    assign s_load = accept & h_valid & ~out_ready & ~s_valid;

    // S drains into H whenever H moves, else refills only on a stall
    wb_payload_reg #(.DW(DATA_W), .RW(RDEST_W)) u_s (
      .clk      (clk),
      .reset    (reset),
      .clr      (flush),
      .load     (s_load | h_load),
      .d_valid  (s_load),
      .d_result (in_result),
      .d_rdest  (in_rdest),
      .d_w_reg  (in_w_reg),
      .d_stop   (in_stop),
      .d_pc     (in_pc),
      .d_bpr    (in_bpr),
      .q_valid  (s_valid),
      .q_result (s_result),
      .q_rdest  (s_rdest),
      .q_w_reg  (s_w_reg),
      .q_stop   (s_stop),
      .q_pc     (s_pc),
      .q_bpr    (s_bpr)
    );

    assign in_ready = ~s_valid;
    assign m_valid  = s_valid | accept;
    assign m_result = s_valid ? s_result : in_result;
    assign m_rdest  = s_valid ? s_rdest  : in_rdest;
    assign m_w_reg  = s_valid ? s_w_reg  : in_w_reg;
    assign m_stop   = s_valid ? s_stop   : in_stop;
    assign m_pc     = s_valid ? s_pc     : in_pc;
    assign m_bpr    = s_valid ? s_bpr    : in_bpr;
  end else begin : g_noskid
    assign s_valid  = 1'b0;
    assign in_ready = h_load;
    assign m_valid  = accept;
    assign m_result = in_result;
    assign m_rdest  = in_rdest;
    assign m_w_reg  = in_w_reg;
    assign m_stop   = in_stop;
    assign m_pc     = in_pc;
    assign m_bpr    = in_bpr;
  end

  wb_payload_reg #(.DW(DATA_W), .RW(RDEST_W)) u_h (
    .clk      (clk),
    .reset    (reset),
    .clr      (flush),
    .load     (h_load),
    .d_valid  (m_valid),
    .d_result (m_result),
    .d_rdest  (m_rdest),
    .d_w_reg  (m_w_reg),
    .d_stop   (m_stop),
    .d_pc     (m_pc),
    .d_bpr    (m_bpr),
    .q_valid  (h_valid),
    .q_result (out_result),
    .q_rdest  (out_rdest),
    .q_w_reg  (out_w_reg),
    .q_stop   (out_stop),
    .q_pc     (out_pc),
    .q_bpr    (out_bpr)
  );

  assign out_valid = h_valid;
  assign fwd_valid = h_valid & out_w_reg;
  assign occupancy = {1'b0, h_valid} + {1'b0, s_valid};
endmodule

// File: tb/tb_mem_wb_elastic_stage.sv
// Scoreboard bench: SKID=1 and SKID=0 instances share stimulus, each
// checked against an in-order queue model of accepted entries.
module tb_mem_wb_elastic_stage;
  typedef struct packed {
    logic [15:0] result;
    logic [2:0]  rdest;
    logic        w;
    logic        st;
    logic [15:0] pc;
    logic        b;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_result = '0;
  logic [2:0]  in_rdest = '0;
  logic        in_w_reg = 1'b0;
  logic        in_stop = 1'b0;
  logic [15:0] in_pc = '0;
  logic        in_bpr = 1'b0;
  logic        out_ready = 1'b0;

  logic        ird1, ov1, ow1, os1, ob1, fwd1;
  logic [15:0] or1, opc1;
  logic [2:0]  ord1;
  logic [1:0]  occ1;
  logic        ird0, ov0, ow0, os0, ob0, fwd0;
  logic [15:0] or0, opc0;
  logic [2:0]  ord0;
  logic [1:0]  occ0;

  int   n_pass = 0;
  int   n_tot  = 0;
  ent_t q1[$];
  ent_t q0[$];

  always #5 clk = ~clk;

  mem_wb_elastic_stage #(.DATA_W(16), .RDEST_W(3), .SKID(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ird1),
    .in_result(in_result), .in_rdest(in_rdest), .in_w_reg(in_w_reg),
    .in_stop(in_stop), .in_pc(in_pc), .in_bpr(in_bpr),
    .out_valid(ov1), .out_ready(out_ready),
    .out_result(or1), .out_rdest(ord1), .out_w_reg(ow1),
    .out_stop(os1), .out_pc(opc1), .out_bpr(ob1),
    .fwd_valid(fwd1), .occupancy(occ1)
  );

  mem_wb_elastic_stage #(.DATA_W(16), .RDEST_W(3), .SKID(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ird0),
    .in_result(in_result), .in_rdest(in_rdest), .in_w_reg(in_w_reg),
    .in_stop(in_stop), .in_pc(in_pc), .in_bpr(in_bpr),
    .out_valid(ov0), .out_ready(out_ready),
    .out_result(or0), .out_rdest(ord0), .out_w_reg(ow0),
    .out_stop(os0), .out_pc(opc0), .out_bpr(ob0),
    .fwd_valid(fwd0), .occupancy(occ0)
  );

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tot++;
    if (got !== exp)
      $display("FAIL %s got=%0h want=%0h at %0t", nm, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic mon_out(input string tag, input logic v, input ent_t got,
                         input logic fwd, input int sz, input ent_t head);
    chk({tag, "_valid"}, v, sz != 0);
    if (sz != 0) begin
      chk({tag, "_payload"}, got, head);
      chk({tag, "_fwd"}, fwd, head.w);
    end else begin
      chk({tag, "_bubble_ctrl"}, {got.rdest, got.w, got.st, got.b}, 0);
      chk({tag, "_bubble_fwd"}, fwd, 0);
    end
  endtask

  // Monitor: compares outputs with the model queue heads each cycle
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        chk("occ1", occ1, q1.size());
        chk("ird1", ird1, q1.size() < 2);
        mon_out("s1", ov1, {or1, ord1, ow1, os1, opc1, ob1}, fwd1,
                q1.size(), q1.size() != 0 ? q1[0] : '0);
        if (out_ready && q1.size() != 0) void'(q1.pop_front());
        chk("occ0", occ0, q0.size());
        chk("ird0", ird0, q0.size() == 0 || out_ready);
        mon_out("s0", ov0, {or0, ord0, ow0, os0, opc0, ob0}, fwd0,
                q0.size(), q0.size() != 0 ? q0[0] : '0);
        if (out_ready && q0.size() != 0) void'(q0.pop_front());
      end
    end
  end

  task automatic cyc(input logic v, input logic [15:0] r,
                     input logic [2:0] rd, input logic w, input logic st,
                     input logic [15:0] pc, input logic b,
                     input logic o, input logic f);
    ent_t e;
    @(negedge clk);
    in_valid = v; in_result = r; in_rdest = rd; in_w_reg = w;
    in_stop = st; in_pc = pc; in_bpr = b; out_ready = o; flush = f;
    #2;
    e = {r, rd, w, st, pc, b};
    if (f) q1.delete();
    else if (v && ird1) q1.push_back(e);
    if (f) q0.delete();
    else if (v && ird0) q0.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #2;
    chk("rst_out_valid", ov1, 0);
    chk("rst_in_ready", ird1, 1);
    chk("rst_occ", occ1, 0);
    #20 reset = 1'b0;

    // Single pass with immediate consumption
    cyc(1'b1, 16'h1234, 3'd5, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b1, 1'b0);
    after_edge();
    chk("pass_valid", ov1, 1);
    chk("pass_result", or1, 16'h1234);
    chk("pass_fwd", fwd1, 1);
    idle(2);

    // Back-pressure fills head and skid, then drains in order
    cyc(1'b1, 16'h0001, 3'd1, 1'b1, 1'b0, 16'h0200, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0002, 3'd2, 1'b1, 1'b0, 16'h0204, 1'b1, 1'b0, 1'b0);
    after_edge();
    chk("bp_occ", occ1, 2);
    chk("bp_in_ready", ird1, 0);
    cyc(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    after_edge();
    chk("bp_second", or1, 16'h0002);
    chk("bp_in_ready_up", ird1, 1);
    idle(2);

    // Flush while full with a new entry offered
    cyc(1'b1, 16'h0011, 3'd3, 1'b1, 1'b1, 16'h0300, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0012, 3'd4, 1'b1, 1'b0, 16'h0304, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0003, 3'd7, 1'b1, 1'b1, 16'h0308, 1'b1, 1'b0, 1'b1);
    after_edge();
    chk("fl_valid", ov1, 0);
    chk("fl_occ", occ1, 0);
    chk("fl_w_reg", ow1, 0);
    chk("fl_in_ready", ird1, 1);
    idle(2);

    // Bubble gating keeps data, zeroes control
    cyc(1'b1, 16'h5555, 3'd6, 1'b1, 1'b0, 16'h0400, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 16'hAAAA, 3'd2, 1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b0);
    after_edge();
    chk("bub_w_reg", ow1, 0);
    chk("bub_rdest", ord1, 0);
    chk("bub_result", or1, 16'h5555);
    chk("bub_pc", opc1, 16'h0400);
    idle(2);

    // SKID=0: combinational ready and a holding head
    cyc(1'b1, 16'h0777, 3'd1, 1'b1, 1'b0, 16'h0500, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("s0_ready_low", ird0, 0);
    cyc(1'b1, 16'h0888, 3'd2, 1'b1, 1'b0, 16'h0504, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("s0_hold", or0, 16'h0777);
    out_ready = 1'b1;
    #1;
    chk("s0_ready_comb", ird0, 1);
    out_ready = 1'b0;
    idle(3);

    // Async reset mid-stream with two entries held
    cyc(1'b1, 16'h0021, 3'd1, 1'b1, 1'b1, 16'h0600, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 16'h0022, 3'd2, 1'b1, 1'b0, 16'h0604, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("mr_occ_full", occ1, 2);
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("mr_valid", ov1, 0);
    chk("mr_payload", {or1, ord1, ow1, os1, opc1, ob1}, 0);
    chk("mr_fwd", fwd1, 0);
    chk("mr_occ", occ1, 0);
    chk("mr_in_ready", ird1, 1);
    chk("mr_occ0", occ0, 0);
    q1.delete();
    q0.delete();
    @(negedge clk);
    #3 reset = 1'b0;

    // Random valid/ready/flush traffic
    for (int i = 0; i < 1000; i++)
      cyc(($urandom % 4) != 0, 16'($urandom), 3'($urandom),
          1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom),
          ($urandom % 3) != 0, ($urandom % 40) == 0);
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
